// File: rtl/gps_pkg.sv
// Shared state encoding, ASCII constants and conversion helpers for gps_utc_local.
// Declarations only: no latency, no flow control.
package gps_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CONV,
    ST_ADJ,
    ST_ROLL,
    ST_OUT
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_DOT  = 8'h2E;

  function automatic logic [4:0] days_in_month(input logic [7:0] month,
                                               input logic [7:0] yy,
                                               input logic       leap_en);
    logic [4:0] days;
    case (month)
      8'd2:                    days = (leap_en && ((yy % 8'd4) == 8'd0)) ? 5'd29 : 5'd28;
      8'd4, 8'd6, 8'd9, 8'd11: days = 5'd30;
      default:                 days = 5'd31;
    endcase
    return days;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
  endfunction

  // Only meaningful when both bytes are digits; garbage otherwise.
  function automatic logic [7:0] ascii2bin(input logic [15:0] pair);
    return (pair[15:8] - ASCII_ZERO) * 8'd10 + (pair[7:0] - ASCII_ZERO);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [7:0] v);
    logic [7:0] tens;
    tens = v / 8'd10;
    return (tens << 4) | (v - tens * 8'd10);
  endfunction

endpackage

// File: rtl/gps_days_in_month.sv
// Combinational (month, yy) -> month length 28..31; zero latency, no flow control.
// GPS_LEAP_YEAR_EN defined: February of every yy%4==0 year has 29 days.
module gps_days_in_month
  import gps_pkg::*;
(
  input  logic [7:0] month,
  input  logic [7:0] yy,
  output logic [4:0] days
);

`ifdef GPS_LEAP_YEAR_EN
  localparam logic LEAP_EN = 1'b1;
`else
  localparam logic LEAP_EN = 1'b0;
`endif

  assign days = days_in_month(month, yy, LEAP_EN);

endmodule

// File: rtl/gps_utc_local.sv
// ASCII GPRMC UTC time/date -> local BCD time/date; local_valid 5 clocks after capture.
// No backpressure: inputs are sampled once quiet; optional GPS_LEAP_YEAR_EN enables Feb 29.
module gps_utc_local
  import gps_pkg::*;
#(
  parameter int TZ_HOURS   = 8,
  parameter int STABLE_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [71:0] time_in,
  input  logic [47:0] date_in,
  output logic [7:0]  loc_hour,
  output logic [7:0]  loc_min,
  output logic [7:0]  loc_sec,
  output logic [7:0]  loc_day,
  output logic [7:0]  loc_month,
  output logic [7:0]  loc_year,
  output logic        date_ok,
  output logic        local_valid,
  output logic        fmt_err
);

  localparam int              CW         = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0]   STABLE_MAX = CW'(STABLE_CYC);
  localparam logic signed [7:0] TZ       = 8'(TZ_HOURS);

  state_t        state, state_nxt;
  logic [71:0]   time_q, snap_time;
  logic [47:0]   date_q, snap_date;
  logic [119:0]  last_pair;
  logic [CW-1:0] stab_cnt;
  logic          has_date;
  logic          capture;
  logic [7:0]    hh_b, mm_b, ss_b, yy_b, mo_b, dd_b;
  logic [7:0]    c_hh, c_mm, c_ss, c_yy, c_mo, c_dd;
  logic          time_dig_ok, date_dig_ok, chk_ok;
  logic [7:0]    prev_mo, prev_yy, next_mo, next_yy, dim_month, dim_year;
  logic [4:0]    dim;
  logic signed [7:0] h_sum;

  // The extractor rewrites fields a byte at a time, so wait for a quiet window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q   <= '0;
      date_q   <= '0;
      stab_cnt <= '0;
    end else begin
      time_q <= time_in;
      date_q <= date_in;
      if ((time_in != time_q) || (date_in != date_q))
        stab_cnt <= '0;
      else if (stab_cnt != STABLE_MAX)
        stab_cnt <= stab_cnt + CW'(1);
    end
  end

  assign capture = (state == ST_IDLE) && (stab_cnt == STABLE_MAX) &&
                   (time_q != '0) && ({time_q, date_q} != last_pair);

  always_comb begin
    time_dig_ok = (snap_time[23:16] == ASCII_DOT);
    for (int i = 0; i < 9; i++)
      if (i != 2) time_dig_ok = time_dig_ok & is_digit(snap_time[i*8 +: 8]);
    date_dig_ok = 1'b1;
    for (int i = 0; i < 6; i++)
      date_dig_ok = date_dig_ok & is_digit(snap_date[i*8 +: 8]);
  end

  assign c_hh = ascii2bin(snap_time[71:56]);
  assign c_mm = ascii2bin(snap_time[55:40]);
  assign c_ss = ascii2bin(snap_time[39:24]);
  assign c_yy = ascii2bin(snap_date[47:32]);
  assign c_mo = ascii2bin(snap_date[31:16]);
  assign c_dd = ascii2bin(snap_date[15:0]);

  assign chk_ok = time_dig_ok && (c_hh <= 8'd23) && (c_mm <= 8'd59) && (c_ss <= 8'd60) &&
                  (!has_date || (date_dig_ok && (c_mo >= 8'd1) && (c_mo <= 8'd12) &&
                                 (c_dd >= 8'd1) && (c_dd <= {3'd0, dim})));

  assign prev_mo = (mo_b == 8'd1) ? 8'd12 : mo_b - 8'd1;
  assign prev_yy = (mo_b != 8'd1) ? yy_b : ((yy_b == 8'd0) ? 8'd99 : yy_b - 8'd1);
  assign next_mo = (mo_b == 8'd12) ? 8'd1 : mo_b + 8'd1;
  assign next_yy = (mo_b != 8'd12) ? yy_b : ((yy_b == 8'd99) ? 8'd0 : yy_b + 8'd1);

  // One lookup serves CHECK (received month) and ROLL (current or previous month).
  assign dim_month = (state == ST_CHECK) ? c_mo : ((dd_b == 8'd0) ? prev_mo : mo_b);
  assign dim_year  = (state == ST_CHECK) ? c_yy : ((dd_b == 8'd0) ? prev_yy : yy_b);

  gps_days_in_month u_dim (
    .month (dim_month),
    .yy    (dim_year),
    .days  (dim)
  );

  assign h_sum = $signed(hh_b) + TZ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (capture) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = chk_ok ? ST_CONV : ST_IDLE;
      ST_CONV:  state_nxt = ST_ADJ;
      ST_ADJ:   state_nxt = ST_ROLL;
      ST_ROLL:  state_nxt = ST_OUT;
      ST_OUT:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_time   <= '0;
      snap_date   <= '0;
      last_pair   <= '0;
      has_date    <= 1'b0;
      hh_b        <= '0;
      mm_b        <= '0;
      ss_b        <= '0;
      yy_b        <= '0;
      mo_b        <= '0;
      dd_b        <= '0;
      loc_hour    <= '0;
      loc_min     <= '0;
      loc_sec     <= '0;
      loc_day     <= '0;
      loc_month   <= '0;
      loc_year    <= '0;
      date_ok     <= 1'b0;
      local_valid <= 1'b0;
      fmt_err     <= 1'b0;
    end else begin
      local_valid <= 1'b0;
      fmt_err     <= 1'b0;
      case (state)
        ST_IDLE: if (capture) begin
          snap_time <= time_q;
          snap_date <= date_q;
          last_pair <= {time_q, date_q};
          has_date  <= |date_q;
        end
        ST_CHECK: fmt_err <= !chk_ok;
        ST_CONV: begin
          hh_b <= c_hh;
          mm_b <= c_mm;
          ss_b <= c_ss;
          yy_b <= c_yy;
          mo_b <= c_mo;
          dd_b <= c_dd;
        end
        ST_ADJ: begin
          if (h_sum >= 8'sd24) begin
            hh_b <= $unsigned(h_sum - 8'sd24);
            if (has_date) dd_b <= dd_b + 8'd1;
          end else if (h_sum < 8'sd0) begin
            hh_b <= $unsigned(h_sum + 8'sd24);
            if (has_date) dd_b <= dd_b - 8'd1;
          end else begin
            hh_b <= $unsigned(h_sum);
          end
        end
        ST_ROLL: if (has_date) begin
          if (dd_b == 8'd0) begin
            dd_b <= {3'd0, dim};
            mo_b <= prev_mo;
            yy_b <= prev_yy;
          end else if (dd_b > {3'd0, dim}) begin
            dd_b <= 8'd1;
            mo_b <= next_mo;
            yy_b <= next_yy;
          end
        end
        ST_OUT: begin
          loc_hour    <= bin2bcd(hh_b);
          loc_min     <= bin2bcd(mm_b);
          loc_sec     <= bin2bcd(ss_b);
          date_ok     <= has_date;
          local_valid <= 1'b1;
          if (has_date) begin
            loc_day   <= bin2bcd(dd_b);
            loc_month <= bin2bcd(mo_b);
            loc_year  <= bin2bcd(yy_b);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gps_utc_local.sv
// Bench for gps_utc_local: an east (+8) and a west (-5) instance share the inputs and
// are compared against a day-index calendar model; honours GPS_LEAP_YEAR_EN.
module tb_gps_utc_local;

  localparam int STABLE = 2000;
  localparam int TZ_E   = 8;
  localparam int TZ_W   = -5;
`ifdef GPS_LEAP_YEAR_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [71:0] time_in = '0;
  logic [47:0] date_in = '0;
  logic [7:0]  e_hour, e_min, e_sec, e_day, e_month, e_year;
  logic [7:0]  w_hour, w_min, w_sec, w_day, w_month, w_year;
  logic        e_date_ok, e_lv, e_fe, w_date_ok, w_lv, w_fe;
  logic [47:0] outs_e, outs_w;

  int checks = 0;
  int failures = 0;
  logic [47:0] exp_e = '0, exp_w = '0;
  logic        exp_e_ok = 1'b0, exp_w_ok = 1'b0;

  always #5 clk = ~clk;

  gps_utc_local #(.TZ_HOURS(TZ_E), .STABLE_CYC(STABLE)) dut_e (
    .clk(clk), .rst_n(rst_n), .time_in(time_in), .date_in(date_in),
    .loc_hour(e_hour), .loc_min(e_min), .loc_sec(e_sec),
    .loc_day(e_day), .loc_month(e_month), .loc_year(e_year),
    .date_ok(e_date_ok), .local_valid(e_lv), .fmt_err(e_fe));

  gps_utc_local #(.TZ_HOURS(TZ_W), .STABLE_CYC(STABLE)) dut_w (
    .clk(clk), .rst_n(rst_n), .time_in(time_in), .date_in(date_in),
    .loc_hour(w_hour), .loc_min(w_min), .loc_sec(w_sec),
    .loc_day(w_day), .loc_month(w_month), .loc_year(w_year),
    .date_ok(w_date_ok), .local_valid(w_lv), .fmt_err(w_fe));

  assign outs_e = {e_hour, e_min, e_sec, e_day, e_month, e_year};
  assign outs_w = {w_hour, w_min, w_sec, w_day, w_month, w_year};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dim_m(input int m, input int y);
    int len[12];
    len = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && LEAP && (y % 4 == 0)) return 29;
    return len[m-1];
  endfunction

  function automatic int ydays(input int y);
    return (LEAP && (y % 4 == 0)) ? 366 : 365;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  // Dates become a day index across 2000..2099 so every carry is a +-1 and a modulo.
  function automatic logic [47:0] model(input int hh, input int mm, input int ss,
                                        input int yy, input int mo, input int dd,
                                        input int tz, input bit has_date,
                                        input logic [23:0] held);
    int h, off, idx, total, y, m;
    h = hh + tz;
    off = 0;
    if (h >= 24) begin h -= 24; off = 1; end
    else if (h < 0) begin h += 24; off = -1; end
    if (!has_date) return {bcd(h), bcd(mm), bcd(ss), held};
    total = 0;
    for (int i = 0; i < 100; i++) total += ydays(i);
    idx = dd - 1 + off;
    for (int i = 0; i < yy; i++) idx += ydays(i);
    for (int i = 1; i < mo; i++) idx += dim_m(i, yy);
    idx = (idx + total) % total;
    y = 0;
    while (idx >= ydays(y)) begin idx -= ydays(y); y++; end
    m = 1;
    while (idx >= dim_m(m, y)) begin idx -= dim_m(m, y); m++; end
    return {bcd(h), bcd(mm), bcd(ss), bcd(idx + 1), bcd(m), bcd(y)};
  endfunction

  function automatic logic [7:0] dig(input int v);
    return 8'(48 + v);
  endfunction

  function automatic logic [71:0] mk_time(input int hh, input int mm, input int ss, input int hs);
    return {dig(hh/10), dig(hh%10), dig(mm/10), dig(mm%10), dig(ss/10), dig(ss%10),
            8'h2E, dig(hs/10), dig(hs%10)};
  endfunction

  function automatic logic [47:0] mk_date(input int yy, input int mo, input int dd);
    return {dig(yy/10), dig(yy%10), dig(mo/10), dig(mo%10), dig(dd/10), dig(dd%10)};
  endfunction

  // Drive a pair on a falling edge, then count falling edges until a strobe (bounded).
  task automatic apply(input logic [71:0] t, input logic [47:0] d,
                       output int lat_v, output int lat_e);
    @(negedge clk);
    time_in = t;
    date_in = d;
    lat_v = -1;
    lat_e = -1;
    for (int n = 1; n <= STABLE + 40; n++) begin
      @(negedge clk);
      if (e_lv) lat_v = n;
      if (e_fe) lat_e = n;
      if (lat_v >= 0 || lat_e >= 0) break;
    end
  endtask

  task automatic conv(input string tag, input int hh, input int mm, input int ss,
                      input int yy, input int mo, input int dd, input bit has_date);
    logic [47:0] ne, nw;
    int lv, fe;
    ne = model(hh, mm, ss, yy, mo, dd, TZ_E, has_date, exp_e[23:0]);
    nw = model(hh, mm, ss, yy, mo, dd, TZ_W, has_date, exp_w[23:0]);
    apply(mk_time(hh, mm, ss, $urandom_range(0, 99)), has_date ? mk_date(yy, mo, dd) : 48'd0, lv, fe);
    check({tag, ".lat"}, 64'(lv), 64'(STABLE + 7));
    check({tag, ".w_vld"}, {63'd0, w_lv}, 64'd1);
    check({tag, ".e_out"}, {16'd0, outs_e}, {16'd0, ne});
    check({tag, ".w_out"}, {16'd0, outs_w}, {16'd0, nw});
    check({tag, ".ok"}, {62'd0, e_date_ok, w_date_ok}, {62'd0, has_date, has_date});
    exp_e = ne;
    exp_w = nw;
    exp_e_ok = has_date;
    exp_w_ok = has_date;
    @(negedge clk);
    check({tag, ".pulse"}, {62'd0, e_lv, w_lv}, 64'd0);
  endtask

  task automatic bad(input string tag, input logic [71:0] t, input logic [47:0] d);
    int lv, fe, seen;
    apply(t, d, lv, fe);
    check({tag, ".err_lat"}, 64'(fe), 64'(STABLE + 3));
    check({tag, ".w_err"}, {63'd0, w_fe}, 64'd1);
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (e_lv || w_lv || e_fe || w_fe) seen++;
    end
    check({tag, ".quiet"}, 64'(seen), 64'd0);
    check({tag, ".held"}, {14'd0, e_date_ok, w_date_ok, outs_e},
          {14'd0, exp_e_ok, exp_w_ok, exp_e});
  endtask

  initial begin
    logic [71:0] t, fin;
    int cnt;

    repeat (3) @(negedge clk);
    check("rst.e_out", {16'd0, outs_e}, 64'd0);
    check("rst.w_out", {16'd0, outs_w}, 64'd0);
    check("rst.flags", {58'd0, e_date_ok, e_lv, e_fe, w_date_ok, w_lv, w_fe}, 64'd0);
    rst_n = 1'b1;

    conv("t1", 2, 35, 43, 13, 2, 24, 1'b1);
    check("t1.lit", {16'd0, outs_e}, {16'd0, 48'h103543_240213});
    conv("t2", 20, 30, 0, 19, 12, 31, 1'b1);
    check("t2.lit", {16'd0, outs_e}, {16'd0, 48'h043000_010120});
    conv("t3", 16, 0, 0, 16, 2, 28, 1'b1);
    check("t3.lit", {16'd0, outs_e}, {16'd0, LEAP ? 48'h000000_290216 : 48'h000000_010316});
    conv("t3w", 3, 0, 0, 20, 3, 1, 1'b1);
    check("t3w.lit", {16'd0, outs_w}, {16'd0, LEAP ? 48'h220000_290220 : 48'h220000_280220});
    conv("wrap_e", 23, 0, 0, 99, 12, 31, 1'b1);
    check("wrap_e.lit", {16'd0, outs_e}, {16'd0, 48'h070000_010100});
    conv("wrap_w", 1, 0, 0, 0, 1, 1, 1'b1);
    check("wrap_w.lit", {16'd0, outs_w}, {16'd0, 48'h200000_311299});
    conv("leapsec", 23, 59, 60, 24, 6, 30, 1'b1);

    bad("e_digit", "2A3543.00", "130224");
    bad("e_hh24", "243543.00", "130224");
    bad("e_mo13", "123543.00", "241302");
    bad("e_mm60", "126000.00", "130224");
    bad("e_dot", "123543,00", "130224");
    bad("e_apr31", "123543.00", "240431");
    bad("e_day0", "123543.00", "240400");
`ifdef GPS_LEAP_YEAR_EN
    conv("feb29", 12, 0, 0, 16, 2, 29, 1'b1);
`else
    bad("e_feb29", "120000.00", "160229");
`endif

    // Byte-by-byte update: only the settled pair may convert, and only once.
    t   = "000000/00";
    fin = "123456.78";
    @(negedge clk);
    time_in = t;
    date_in = mk_date(15, 6, 15);
    cnt = 0;
    for (int b = 8; b >= 0; b--) begin
      for (int n = 0; n < 1000; n++) begin
        @(negedge clk);
        if (e_lv || e_fe) cnt++;
      end
      t[b*8 +: 8] = fin[b*8 +: 8];
      time_in = t;
    end
    for (int n = 0; n < 2 * STABLE + 200; n++) begin
      @(negedge clk);
      if (e_lv || e_fe) cnt++;
    end
    check("t4.one_strobe", 64'(cnt), 64'd1);
    exp_e = model(12, 34, 56, 15, 6, 15, TZ_E, 1'b1, exp_e[23:0]);
    exp_w = model(12, 34, 56, 15, 6, 15, TZ_W, 1'b1, exp_w[23:0]);
    check("t4.e_out", {16'd0, outs_e}, {16'd0, exp_e});
    check("t4.w_out", {16'd0, outs_w}, {16'd0, exp_w});
    @(negedge clk);
    date_in = mk_date(15, 6, 16);
    @(negedge clk);
    date_in = mk_date(15, 6, 15);
    cnt = 0;
    for (int n = 0; n < STABLE + 100; n++) begin
      @(negedge clk);
      if (e_lv || e_fe) cnt++;
    end
    check("t4.no_reconv", 64'(cnt), 64'd0);

    // Reset while the converter sits in ADJ.
    @(negedge clk);
    time_in = mk_time(9, 0, 0, 0);
    date_in = mk_date(21, 5, 5);
    repeat (STABLE + 4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6.rst_e", {13'd0, e_date_ok, e_lv, e_fe, outs_e}, 64'd0);
    check("t6.rst_w", {13'd0, w_date_ok, w_lv, w_fe, outs_w}, 64'd0);
    exp_e = '0;
    exp_w = '0;
    exp_e_ok = 1'b0;
    exp_w_ok = 1'b0;
    cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (e_lv || w_lv || e_fe || w_fe) cnt++;
    end
    check("t6.no_strobe", 64'(cnt), 64'd0);
    check("t6.outs_zero", {16'd0, outs_e}, 64'd0);

    conv("t6.nodate", 20, 15, 30, 0, 0, 0, 1'b0);
    check("t6.nodate_lit", {16'd0, outs_e}, {16'd0, 48'h041530_000000});

    for (int i = 0; i < 8; i++) begin
      int hh, mm, ss, yy, mo, dd;
      bit hd;
      hh = $urandom_range(0, 23);
      mm = $urandom_range(0, 59);
      ss = $urandom_range(0, 60);
      yy = $urandom_range(0, 99);
      mo = $urandom_range(1, 12);
      dd = $urandom_range(1, dim_m(mo, yy));
      if (i < 2) dd = dim_m(mo, yy);
      hd = ($urandom_range(0, 5) != 0);
      conv($sformatf("rnd%0d", i), hh, mm, ss, yy, mo, dd, hd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
